// File: rtl/step_control_if.sv
// Handshake bundle between the step controller, its step counter and the datapath.
// The master side is the controller; the slave side is counter/datapath/environment.
interface step_control_if #(
    parameter int L_COUNT = 3,
    parameter int N_REG   = 8,
    parameter int L_ICNT  = 16
);
    logic               RUN;
    logic [8:0]         DIN;
    logic [L_COUNT-1:0] TSTEP;
    logic               CNT_CLR;
    logic               IR_IN;
    logic [N_REG-1:0]   R_IN;
    logic [N_REG-1:0]   R_OUT;
    logic               A_IN;
    logic               G_IN;
    logic               G_OUT;
    logic               DIN_OUT;
    logic               ADDSUB;
    logic               DONE;
    logic               ERR;
    logic [L_ICNT-1:0]  ICNT;

    modport master (
        input  RUN, DIN, TSTEP,
        output CNT_CLR, IR_IN, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT,
               ADDSUB, DONE, ERR, ICNT
    );

    modport slave (
        output RUN, DIN, TSTEP,
        input  CNT_CLR, IR_IN, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT,
               ADDSUB, DONE, ERR, ICNT
    );
endinterface

// File: rtl/step_control.sv
// Multi-cycle processor control: latches the instruction, decodes (IR, step) into strobes.
// Strobes are combinational from state/IR/TSTEP; RUN is only honoured in IDLE at step 0.
module step_control #(
    parameter int L_COUNT = 3,
    parameter int STOP    = 6,
    parameter int N_REG   = 8,
    parameter int L_ICNT  = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    step_control_if.master bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]        state;
    logic [8:0]        ir;
    logic              err;
    logic [L_ICNT-1:0] icnt;

    logic [2:0]       op;
    logic [2:0]       rx;
    logic [2:0]       ry;
    logic             cnt_clr;
    logic             ir_in;
    logic [N_REG-1:0] r_in;
    logic [N_REG-1:0] r_out;
    logic             a_in;
    logic             g_in;
    logic             g_out;
    logic             din_out;
    logic             addsub;
    logic             done;
    logic             fault;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    always_comb begin
        cnt_clr = 1'b1;
        ir_in   = 1'b0;
        r_in    = '0;
        r_out   = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        if (state == IDLE) begin
            // A fetch needs the counter parked at step 0; otherwise keep clearing it.
            ir_in   = bus.RUN && (bus.TSTEP == '0);
            cnt_clr = ~ir_in;
        end else begin
            if (bus.TSTEP == L_COUNT'(STOP)) begin
                done  = 1'b1;
                fault = 1'b1;
            end else begin
                case (op)
                    3'b000: if (bus.TSTEP == L_COUNT'(1)) begin
                        r_out = N_REG'(1) << ry;
                        r_in  = N_REG'(1) << rx;
                        done  = 1'b1;
                    end
                    3'b001: if (bus.TSTEP == L_COUNT'(1)) begin
                        din_out = 1'b1;
                        r_in    = N_REG'(1) << rx;
                        done    = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        if (bus.TSTEP == L_COUNT'(1)) begin
                            r_out = N_REG'(1) << rx;
                            a_in  = 1'b1;
                        end else if (bus.TSTEP == L_COUNT'(2)) begin
                            r_out  = N_REG'(1) << ry;
                            g_in   = 1'b1;
                            addsub = op[0];
                        end else if (bus.TSTEP == L_COUNT'(3)) begin
                            g_out = 1'b1;
                            r_in  = N_REG'(1) << rx;
                            done  = 1'b1;
                        end
                    end
                    default: if (bus.TSTEP == L_COUNT'(1)) begin
                        done  = 1'b1;
                        fault = 1'b1;
                    end
                endcase
            end
            cnt_clr = done;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            ir    <= '0;
            err   <= 1'b0;
            icnt  <= '0;
        end else if (state == IDLE) begin
            if (ir_in) begin
                ir    <= bus.DIN;
                state <= ACTIVE;
            end
        end else if (done) begin
            state <= IDLE;
            icnt  <= icnt + L_ICNT'(1);
            if (fault) err <= 1'b1;
        end
    end

    assign bus.CNT_CLR = cnt_clr;
    assign bus.IR_IN   = ir_in;
    assign bus.R_IN    = r_in;
    assign bus.R_OUT   = r_out;
    assign bus.A_IN    = a_in;
    assign bus.G_IN    = g_in;
    assign bus.G_OUT   = g_out;
    assign bus.DIN_OUT = din_out;
    assign bus.ADDSUB  = addsub;
    assign bus.DONE    = done;
    assign bus.ERR     = err;
    assign bus.ICNT    = icnt;
endmodule
